// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 byte transmitter: state enums,
// LCD bus bit positions, the power-up command ROM and the long-wait opcodes.
package lcd_pkg;

    typedef enum logic [1:0] {
        SEQ_PWR,
        SEQ_INIT,
        SEQ_IDLE
    } seq_state_t;

    typedef enum logic [2:0] {
        ENG_PWR,
        ENG_IDLE,
        ENG_SETUP,
        ENG_PULSE,
        ENG_HOLD,
        ENG_WAIT
    } eng_state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } lcd_byte_t;

    localparam int unsigned LCD_W        = 13;
    localparam int unsigned LCD_ON_BIT   = 12;
    localparam int unsigned LCD_BLON_BIT = 11;
    localparam int unsigned LCD_EN_BIT   = 10;
    localparam int unsigned LCD_RS_BIT   = 9;
    localparam int unsigned LCD_RW_BIT   = 8;

    // Function set 8-bit/2-line, display on, clear, entry mode increment
    localparam int unsigned INIT_LEN   = 4;
    localparam int unsigned INIT_IDX_W = 3;
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Clear display / return home need the long execution wait
    localparam int unsigned CLR_OPS_N = 3;
    localparam logic [CLR_OPS_N-1:0][7:0] CLR_OPS = {8'h03, 8'h02, 8'h01};

    function automatic logic is_long_cmd(input lcd_byte_t b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < CLR_OPS_N; i++) begin
            if (b.data == CLR_OPS[i]) hit = 1'b1;
        end
        return !b.rs && hit;
    endfunction

endpackage

// File: rtl/lcd_byte_tx_if.sv
// Request handshake between the LCD peripheral (master) and the transmitter (slave).
interface lcd_byte_tx_if;
    logic       req_vld_i;
    logic       req_rs_i;
    logic [7:0] req_data_i;
    logic       req_rdy_o;

    modport master (output req_vld_i, output req_rs_i, output req_data_i, input req_rdy_o);
    modport slave  (input req_vld_i, input req_rs_i, input req_data_i, output req_rdy_o);
endinterface

// File: rtl/lcd_byte_engine.sv
// One-byte LCD write engine: SETUP/PULSE/HOLD/WAIT on a single shared down-counter,
// which also times the power-up delay straight out of reset.
module lcd_byte_engine
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_HIGH_CYC  = 25,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000,
    parameter int unsigned PWRUP_CYC    = 750000,
    parameter int unsigned INIT_EN      = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      start,
    input  lcd_byte_t start_byte,
    output logic      free_c,
    output logic      free_nxt_c,
    output logic      en,
    output lcd_byte_t cur_byte
);
    localparam int unsigned MAX_0   = (SETUP_CYC > EN_HIGH_CYC) ? SETUP_CYC : EN_HIGH_CYC;
    localparam int unsigned MAX_1   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
    localparam int unsigned MAX_2   = (CLR_WAIT_CYC > PWRUP_CYC) ? CLR_WAIT_CYC : PWRUP_CYC;
    localparam int unsigned MAX_01  = (MAX_0 > MAX_1) ? MAX_0 : MAX_1;
    localparam int unsigned MAX_CYC = (MAX_01 > MAX_2) ? MAX_01 : MAX_2;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    localparam eng_state_t       ST_RST  = (INIT_EN != 0) ? ENG_PWR : ENG_IDLE;
    localparam logic [CNT_W-1:0] CNT_RST = (INIT_EN != 0) ? CNT_W'(PWRUP_CYC - 1) : '0;

    eng_state_t       st, st_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    lcd_byte_t        byte_nxt;
    logic             take_c;

    // The last WAIT cycle doubles as an accept slot so back-to-back bytes have no bubble
    assign free_c = (st == ENG_IDLE) || ((st == ENG_WAIT) && (cnt == '0));
    assign take_c = start && free_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st       <= ST_RST;
            cnt      <= CNT_RST;
            cur_byte <= '0;
            en       <= 1'b0;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            cur_byte <= byte_nxt;
            en       <= (st_nxt == ENG_PULSE);
        end
    end

    always_comb begin
        st_nxt   = st;
        cnt_nxt  = cnt;
        byte_nxt = cur_byte;
        if (take_c) begin
            st_nxt   = ENG_SETUP;
            cnt_nxt  = CNT_W'(SETUP_CYC - 1);
            byte_nxt = start_byte;
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end else begin
            case (st)
                ENG_PWR:   st_nxt = ENG_IDLE;
                ENG_SETUP: begin
                    st_nxt  = ENG_PULSE;
                    cnt_nxt = CNT_W'(EN_HIGH_CYC - 1);
                end
                ENG_PULSE: begin
                    st_nxt  = ENG_HOLD;
                    cnt_nxt = CNT_W'(HOLD_CYC - 1);
                end
                ENG_HOLD: begin
                    st_nxt  = ENG_WAIT;
                    cnt_nxt = is_long_cmd(cur_byte) ? CNT_W'(CLR_WAIT_CYC - 1)
                                                    : CNT_W'(CMD_WAIT_CYC - 1);
                end
                ENG_WAIT:  st_nxt = ENG_IDLE;
                default:   st_nxt = st;
            endcase
        end
        free_nxt_c = (st_nxt == ENG_IDLE) || ((st_nxt == ENG_WAIT) && (cnt_nxt == '0));
    end

endmodule

// File: rtl/lcd_byte_tx.sv
// HD44780 byte transmitter top: power-up/init/idle sequencer and request handshake
// in front of the byte engine; drives the 13-bit LCD bus from registers only.
module lcd_byte_tx
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC    = 2,
    parameter int unsigned EN_HIGH_CYC  = 25,
    parameter int unsigned HOLD_CYC     = 2,
    parameter int unsigned CMD_WAIT_CYC = 2000,
    parameter int unsigned CLR_WAIT_CYC = 82000,
    parameter int unsigned PWRUP_CYC    = 750000,
    parameter int unsigned INIT_EN      = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    lcd_byte_tx_if.slave     req,
    input  logic             on_i,
    input  logic             blon_i,
    output logic             init_done_o,
    output logic [LCD_W-1:0] lcd_o
);
    localparam seq_state_t SEQ_RST = (INIT_EN != 0) ? SEQ_PWR : SEQ_IDLE;

    seq_state_t             seq, seq_nxt;
    logic [INIT_IDX_W-1:0]  idx, idx_nxt;
    logic                   rdy_q, done_q, on_q, blon_q;
    logic                   eng_start_c, eng_free_c, eng_free_nxt_c, eng_en;
    lcd_byte_t              eng_byte_c, eng_cur;

    lcd_byte_engine #(
        .SETUP_CYC   (SETUP_CYC),
        .EN_HIGH_CYC (EN_HIGH_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .CMD_WAIT_CYC(CMD_WAIT_CYC),
        .CLR_WAIT_CYC(CLR_WAIT_CYC),
        .PWRUP_CYC   (PWRUP_CYC),
        .INIT_EN     (INIT_EN)
    ) u_engine (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start      (eng_start_c),
        .start_byte (eng_byte_c),
        .free_c     (eng_free_c),
        .free_nxt_c (eng_free_nxt_c),
        .en         (eng_en),
        .cur_byte   (eng_cur)
    );

    // Byte source: init ROM while initialising, request port once idle
    always_comb begin
        eng_start_c = 1'b0;
        eng_byte_c  = '{rs: 1'b0, data: INIT_ROM[idx[1:0]]};
        case (seq)
            SEQ_INIT: eng_start_c = (idx != INIT_IDX_W'(INIT_LEN)) && eng_free_c;
            SEQ_IDLE: begin
                eng_start_c = req.req_vld_i && rdy_q;
                eng_byte_c  = '{rs: req.req_rs_i, data: req.req_data_i};
            end
            default: eng_start_c = 1'b0;
        endcase
    end

    always_comb begin
        seq_nxt = seq;
        idx_nxt = idx;
        case (seq)
            SEQ_PWR:  if (eng_free_nxt_c) seq_nxt = SEQ_INIT;
            SEQ_INIT: begin
                if (eng_start_c) idx_nxt = idx + INIT_IDX_W'(1);
                if ((idx_nxt == INIT_IDX_W'(INIT_LEN)) && eng_free_nxt_c) seq_nxt = SEQ_IDLE;
            end
            default:  seq_nxt = seq;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq    <= SEQ_RST;
            idx    <= '0;
            rdy_q  <= 1'b0;
            done_q <= 1'b0;
            on_q   <= 1'b0;
            blon_q <= 1'b0;
        end else begin
            seq    <= seq_nxt;
            idx    <= idx_nxt;
            rdy_q  <= (seq_nxt == SEQ_IDLE) && eng_free_nxt_c;
            done_q <= done_q || (seq_nxt == SEQ_IDLE);
            on_q   <= on_i;
            blon_q <= blon_i;
        end
    end

    assign req.req_rdy_o = rdy_q;
    assign init_done_o   = done_q;

    always_comb begin
        lcd_o               = '0;
        lcd_o[LCD_ON_BIT]   = on_q;
        lcd_o[LCD_BLON_BIT] = blon_q;
        lcd_o[LCD_EN_BIT]   = eng_en;
        lcd_o[LCD_RS_BIT]   = eng_cur.rs;
        lcd_o[LCD_RW_BIT]   = 1'b0;
        lcd_o[7:0]          = eng_cur.data;
    end

endmodule

// File: doc/lcd_byte_tx.md
# lcd_byte_tx

Hardware transmitter for the board's HD44780-compatible character LCD. It drives the 13-bit LCD bus directly and generates the EN strobe and command-execution delays in hardware. It accepts {RS, byte} requests over a valid/ready handshake and runs the power-up init sequence itself. It sits between the core's LCD peripheral register (or a test driver) and the board LCD pins, in place of software bit-banging.

## Interface
- `SETUP_CYC`, default 2: cycles RS/DATA are stable before EN rises (≥40 ns at 50 MHz).
- `EN_HIGH_CYC`, default 25: EN high width in cycles (500 ns).
- `HOLD_CYC`, default 2: cycles RS/DATA are held after EN falls.
- `CMD_WAIT_CYC`, default 2000: execution wait after a normal byte (40 µs).
- `CLR_WAIT_CYC`, default 82000: execution wait after clear/home (1.64 ms).
- `PWRUP_CYC`, default 750000: wait after reset before init (15 ms).
- `INIT_EN`, default 1: 1 = run the init sequence after reset; 0 = go straight to idle.

Ports:
- `clk_i` in, 1: single clock, rising edge.
- `rst_i` in, 1: asynchronous, active-high reset.
- `req_vld_i` in, 1: request valid.
- `req_rs_i` in, 1: 0 = command, 1 = data.
- `req_data_i` in, 8: byte to send.
- `req_rdy_o` out, 1: ready to accept a request.
- `on_i` in, 1: LCD power enable, passed to `lcd_o[12]`.
- `blon_i` in, 1: backlight enable, passed to `lcd_o[11]`.
- `init_done_o` out, 1: init sequence complete; sticky until reset.
- `lcd_o` out, 13: LCD bus.
  - [12] ON, [11] BLON, [10] EN, [9] RS, [8] RW, [7:0] DATA.
  - RW is always 0 (write-only).

## Operation
- Top sequencer states: PWR → INIT → IDLE.
- Byte engine states: SETUP → PULSE → HOLD → WAIT → done.
- **PWR:** count `PWRUP_CYC` cycles, then enter INIT. If `INIT_EN`=0, reset goes directly to IDLE and `init_done_o`=1.
- **INIT:** issues 0x38, 0x0C, 0x01, 0x06 in order, all with RS=0, through the byte engine. After the last byte's WAIT completes: `init_done_o`=1, enter IDLE.
- **IDLE:** `req_rdy_o`=1. A request is accepted on `req_vld_i & req_rdy_o`; RS and DATA are latched and the engine starts.
- Byte engine phases:
  - SETUP: EN=0, RS/DATA driven, `SETUP_CYC` cycles.
  - PULSE: EN=1, `EN_HIGH_CYC` cycles.
  - HOLD: EN=0, RS/DATA unchanged, `HOLD_CYC` cycles.
  - WAIT: EN=0, `CLR_WAIT_CYC` cycles if RS=0 and DATA ∈ {0x01, 0x02, 0x03}; otherwise `CMD_WAIT_CYC`.
- After WAIT, return to IDLE (or to the next init byte).
- RS/DATA keep their last value in IDLE.
- `req_data_i`/`req_rs_i` are ignored when not accepted. Changes to them during a transfer have no effect.
- `on_i`/`blon_i` are registered into `lcd_o[12:11]` every cycle, in every state.

## Timing
- All outputs are registered.
- Reset values:
  - `lcd_o` = 13'h0000.
  - `req_rdy_o` = 0.
  - `init_done_o` = 0.
  - When `INIT_EN`=0, `req_rdy_o` and `init_done_o` become 1 on the first clock edge after reset deasserts.
- Acceptance at edge N: `req_rdy_o`=0 from N+1, and SETUP begins at N+1 with new RS/DATA.
- EN rises at N+1+`SETUP_CYC`, falls at N+1+`SETUP_CYC`+`EN_HIGH_CYC`.
- `req_rdy_o` returns to 1 at N+1+`SETUP_CYC`+`EN_HIGH_CYC`+`HOLD_CYC`+wait.
- Each phase lasts exactly its parameter count; all parameters must be ≥1.
- One shared down-counter of width $clog2(max of all parameters)+1. It is loaded on each state entry; the state exits when the count reaches 0.
- Back-to-back requests: a new request can be accepted in the same cycle `req_rdy_o` is high. There are no idle bubbles beyond the mandated wait.
- `req_vld_i` held high while `req_rdy_o`=0 is a no-op; the request is accepted when ready returns.
- Reset mid-transfer: `rst_i` asserted forces EN=0 and all outputs to reset values immediately (asynchronous). The byte in flight is dropped, and init restarts from PWR after deassertion.

## Structure
- `lcd_pkg` holds:
  - Sequencer and engine state enums.
  - Bit-index constants: `LCD_ON_BIT`=12, `LCD_BLON_BIT`=11, `LCD_EN_BIT`=10, `LCD_RS_BIT`=9, `LCD_RW_BIT`=8.
  - The 4-entry init command ROM constant.
  - The clear/home opcode list.
- One sub-module, `lcd_byte_engine`: SETUP/PULSE/HOLD/WAIT FSM plus counter, with start/done handshake.
- The top level holds the PWR/INIT/IDLE sequencer, init index, and handshake.

## Test plan
Bench parameters: `SETUP_CYC`=2, `EN_HIGH_CYC`=4, `HOLD_CYC`=2, `CMD_WAIT_CYC`=10, `CLR_WAIT_CYC`=40, `PWRUP_CYC`=20.

- **Init, `INIT_EN`=1:** release reset → exactly four EN pulses with DATA 0x38, 0x0C, 0x01, 0x06 and RS=0. The first EN rises 20+1+2 cycles after reset release. The gap after 0x01 is 40 wait cycles; the other gaps are 10. `init_done_o`=1 with `req_rdy_o`=1 after the last wait.
- **Data byte:** send RS=1, 0x41 → `lcd_o[9]`=1, `lcd_o[7:0]`=0x41. EN is high for exactly 4 cycles starting 3 cycles after acceptance. `req_rdy_o` returns 18 cycles after acceptance. RW=0 throughout.
- **Clear wait:** send RS=0, 0x01 → `req_rdy_o` returns 48 cycles after acceptance. RS=1 with 0x01 returns after 18 cycles.
- **Back-to-back:** hold `req_vld_i` high for 3 bytes → 3 EN pulses spaced 18 cycles apart. Bytes arrive in order; no request is lost or duplicated.
- **Reset mid-pulse:** assert `rst_i` while EN=1 → `lcd_o`=0 in the same cycle, before the next edge. After release, no EN pulse occurs for 20 cycles, then init restarts with 0x38.
- **Passthrough:** toggle `on_i`/`blon_i` in IDLE and mid-transfer → `lcd_o[12:11]` follows one cycle later. EN timing is unaffected.
